// File: rtl/jt053245_pkg.sv
// Shared types and constants for the k053245 line-draw slice.
package jt053245_pkg;

  // Fetch/draw sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH0 = 2'd1,
    ST_FETCH1 = 2'd2,
    ST_DRAW   = 2'd3
  } state_t;

  // hzoom value for 1:1 scaling (also the size of one source pixel in acc units)
  localparam int ZOOM_ONE = 'h40;
  // Source pixels per tile row
  localparam int TILE_W   = 16;
  // Accumulator value marking the end of the source row
  localparam int ACC_END  = TILE_W * ZOOM_ONE;

  // Line-buffer word: colour/priority attributes above the 4bpp pixel
  typedef struct packed {
    logic [9:0] attr;
    logic [3:0] pix;
  } buf_word_t;

  // Pick source pixel idx from a 64-bit row; pixel 0 sits in the top nibble
  function automatic logic [3:0] row_nibble(input logic [63:0] row, input logic [3:0] idx);
    return row[{~idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/jt053245_hzacc.sv
// Horizontal zoom accumulator: walks source pixels in 1/UNIT-pixel steps,
// flags the last output pixel and exposes the leftover fraction.
module jt053245_hzacc
  import jt053245_pkg::*;
#(
  parameter  int MAXW   = 256,
  parameter  int UNIT   = 64,
  localparam int FRAC_W = $clog2(UNIT),
  localparam int SEL_W  = $clog2(TILE_W)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keep,
  input  logic              step,
  input  logic [FRAC_W-1:0] resid,
  input  logic [11:0]       hzoom,
  output logic [SEL_W-1:0]  s,
  output logic              last,
  output logic [FRAC_W-1:0] frac
);

  // Room for the largest pre-end value plus the largest zoom step
  localparam int ACC_W = 13;
  localparam int CNT_W = $clog2(MAXW);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;

  assign acc_d = acc_q + ACC_W'(hzoom);
  assign s     = acc_q[FRAC_W +: SEL_W];
  // End on running past the source row, or on the output-width cap
  assign last  = (acc_d >= ACC_W'(ACC_END)) || (cnt_q == CNT_W'(MAXW - 1));
  assign frac  = acc_d[FRAC_W-1:0];

  // Load at row start (optionally resuming the carried fraction), step per output pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= keep ? ACC_W'(resid) : '0;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/jt053245_linedraw.sv
// k053245 draw side: latches one tile row from the scanner, fetches its two
// ROM words, then scales it horizontally into the sprite line buffer.
module jt053245_linedraw
  import jt053245_pkg::*;
#(
  parameter int MAXW     = 256,
  parameter int ZOOM_ONE = jt053245_pkg::ZOOM_ONE
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [9:0]  attr,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [8:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [11:0] hzoom,
  input  logic        hz_keep,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic [8:0]  buf_addr,
  output logic [13:0] buf_din,
  output logic        buf_we
);

  localparam int FRAC_W = $clog2(ZOOM_ONE);

  state_t      state_q;
  logic        busy_q;
  logic        cs_q;
  logic [20:0] rom_addr_q;
  logic        we_q;
  logic [8:0]  baddr_q;
  buf_word_t   bdin_q;
  logic [8:0]  x_q;
  logic [8:0]  lastx_q;
  logic [FRAC_W-1:0] frac_q;

  // Row context captured at dr_start / from the ROM
  logic [9:0]  attr_q;
  logic        hflip_q;
  logic        keep_q;
  logic [8:0]  hpos_q;
  logic [11:0] hzoom_q;
  logic [31:0] word0_q;
  logic [31:0] word1_q;

  logic        take;
  logic        got0;
  logic        got1;
  logic        drawing;
  logic [3:0]  s;
  logic [3:0]  sp;
  logic [3:0]  pix;
  logic        last;
  logic [FRAC_W-1:0] frac;

  // A second start while busy (including the tail cycle in IDLE) is dropped
  assign take    = (state_q == ST_IDLE) && dr_start && !busy_q;
  assign got0    = (state_q == ST_FETCH0) && rom_ok;
  // rom_ok only counts once the second request is actually on the bus
  assign got1    = (state_q == ST_FETCH1) && cs_q && rom_ok;
  assign drawing = (state_q == ST_DRAW);
  assign sp      = hflip_q ? ~s : s;
  assign pix     = row_nibble({word0_q, word1_q}, sp);

  assign dr_busy  = busy_q;
  assign rom_cs   = cs_q;
  assign rom_addr = rom_addr_q;
  assign buf_we   = we_q;
  assign buf_addr = baddr_q;
  assign buf_din  = bdin_q;

  jt053245_hzacc #(
    .MAXW (MAXW),
    .UNIT (ZOOM_ONE)
  ) u_hzacc (
    .clk   (clk),
    .rst   (rst),
    .start (got1),
    .keep  (keep_q),
    .step  (drawing),
    .resid (frac_q),
    .hzoom (hzoom_q),
    .s     (s),
    .last  (last),
    .frac  (frac)
  );

  // Hold the row parameters and ROM words for the duration of the row
  always_ff @(posedge clk) begin
    if (take) begin
      attr_q  <= attr;
      hflip_q <= hflip;
      keep_q  <= hz_keep;
      hpos_q  <= hpos;
      hzoom_q <= hzoom;
    end
    if (got0) word0_q <= rom_data;
    if (got1) word1_q <= rom_data;
  end

  // Fetch/draw sequencer with registered ROM and line-buffer outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      cs_q       <= 1'b0;
      rom_addr_q <= '0;
      we_q       <= 1'b0;
      baddr_q    <= '0;
      bdin_q     <= '0;
      x_q        <= '0;
      lastx_q    <= '0;
      frac_q     <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_q    <= ST_FETCH0;
            busy_q     <= 1'b1;
            cs_q       <= 1'b1;
            rom_addr_q <= {code, (vflip ? ~ysub : ysub), 1'b0};
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_FETCH0: begin
          if (got0) begin
            cs_q    <= 1'b0;
            state_q <= ST_FETCH1;
          end
        end
        ST_FETCH1: begin
          // Entry cycle keeps rom_cs low, giving the gap between requests
          if (!cs_q) begin
            cs_q          <= 1'b1;
            rom_addr_q[0] <= 1'b1;
          end else if (got1) begin
            cs_q    <= 1'b0;
            state_q <= ST_DRAW;
            x_q     <= keep_q ? lastx_q + 9'd1 : hpos_q;
          end
        end
        ST_DRAW: begin
          we_q    <= (pix != 4'd0);
          baddr_q <= x_q;
          bdin_q  <= '{attr: attr_q, pix: pix};
          x_q     <= x_q + 9'd1;
          if (last) begin
            lastx_q <= x_q;
            frac_q  <= frac;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt053245_linedraw.sv
// Directed bench for jt053245_linedraw.
module tb_jt053245_linedraw;

  logic        clk = 1'b0;
  logic        rst;
  logic        dr_start;
  logic        dr_busy;
  logic [15:0] code;
  logic [9:0]  attr;
  logic        hflip;
  logic        vflip;
  logic [8:0]  hpos;
  logic [3:0]  ysub;
  logic [11:0] hzoom;
  logic        hz_keep;
  logic [20:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok;
  logic [31:0] rom_data;
  logic [8:0]  buf_addr;
  logic [13:0] buf_din;
  logic        buf_we;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] rw0;
  logic [31:0] rw1;
  int          rom_delay = 0;

  int          wx[$];
  logic [13:0] wd[$];
  logic [20:0] cs_addr[$];
  int          cs_run[$];
  int          cs_gap[$];
  int          first_we_cyc  = -1;
  int          last_we_cyc   = -1;
  int          start_cyc     = 0;
  int          busy_fall_cyc = 0;

  jt053245_linedraw dut (
    .clk      (clk),
    .rst      (rst),
    .dr_start (dr_start),
    .dr_busy  (dr_busy),
    .code     (code),
    .attr     (attr),
    .hflip    (hflip),
    .vflip    (vflip),
    .hpos     (hpos),
    .ysub     (ysub),
    .hzoom    (hzoom),
    .hz_keep  (hz_keep),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_ok   (rom_ok),
    .rom_data (rom_data),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .buf_we   (buf_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: answers a held request after rom_delay extra cycles, ok lasts one cycle
  initial begin : rom_model
    int wait_cnt;
    wait_cnt = 0;
    rom_ok   = 1'b0;
    rom_data = '0;
    forever begin
      @(negedge clk);
      if (rom_ok) begin
        rom_ok   = 1'b0;
        wait_cnt = 0;
      end else if (rom_cs) begin
        if (wait_cnt >= rom_delay) begin
          rom_ok   = 1'b1;
          rom_data = rom_addr[0] ? rw1 : rw0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: line-buffer writes and rom_cs pulse/gap lengths
  initial begin : monitor
    logic prev_cs;
    int   run_len;
    int   gap_len;
    prev_cs = 1'b0;
    run_len = 0;
    gap_len = 0;
    forever begin
      @(negedge clk);
      if (buf_we) begin
        if (wx.size() == 0) first_we_cyc = cyc;
        wx.push_back(int'(buf_addr));
        wd.push_back(buf_din);
        last_we_cyc = cyc;
      end
      if (rom_cs && !prev_cs) begin
        cs_addr.push_back(rom_addr);
        if (cs_addr.size() > 1) cs_gap.push_back(gap_len);
        run_len = 0;
      end
      if (!rom_cs && prev_cs) begin
        cs_run.push_back(run_len);
        gap_len = 0;
      end
      if (rom_cs) run_len++;
      else        gap_len++;
      prev_cs = rom_cs;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wx.delete();
    wd.delete();
    cs_addr.delete();
    cs_run.delete();
    cs_gap.delete();
    first_we_cyc = -1;
    last_we_cyc  = -1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (dr_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    busy_fall_cyc = cyc;
    chk({tag, "_busy_timeout"}, (n < 2000), 1);
  endtask

  task automatic set_row(input logic [15:0] c, input logic [9:0] a, input logic hf,
                         input logic vf, input logic [8:0] hp, input logic [3:0] ys,
                         input logic [11:0] hz, input logic kp);
    code = c; attr = a; hflip = hf; vflip = vf;
    hpos = hp; ysub = ys; hzoom = hz; hz_keep = kp;
  endtask

  task automatic run_row(input string tag, input logic [15:0] c, input logic [9:0] a,
                         input logic hf, input logic vf, input logic [8:0] hp,
                         input logic [3:0] ys, input logic [11:0] hz, input logic kp,
                         input int hold);
    @(negedge clk);
    clear_mon();
    set_row(c, a, hf, vf, hp, ys, hz, kp);
    dr_start  = 1'b1;
    start_cyc = cyc;
    repeat (hold) @(negedge clk);
    dr_start = 1'b0;
    wait_idle(tag);
  endtask

  // Expected writes: output pixel i samples source pixel (acc0 + i*zoom)/64
  task automatic check_row(input string tag, input int n_pix, input int n_wr, input int x0,
                           input logic hf, input int zoom, input int acc0, input logic [9:0] a);
    logic [63:0] row;
    logic [3:0]  s;
    logic [3:0]  sp;
    logic [3:0]  p;
    int          acc;
    int          j;
    row = {rw0, rw1};
    j   = 0;
    for (int i = 0; i < n_pix; i++) begin
      acc = acc0 + i * zoom;
      s   = acc[9:6];
      sp  = hf ? 4'(15 - s) : s;
      p   = row[63 - 4 * sp -: 4];
      if (p != 4'd0) begin
        if (j < wx.size()) begin
          chk({tag, "_x"}, wx[j], (x0 + i) % 512);
          chk({tag, "_din"}, {18'd0, wd[j]}, {18'd0, a, p});
        end
        j++;
      end
    end
    chk({tag, "_nwr"}, wx.size(), n_wr);
  endtask

  initial begin : stim
    int n;
    rst = 1'b1;
    dr_start = 1'b0;
    set_row(16'h0, 10'h0, 1'b0, 1'b0, 9'd0, 4'd0, 12'h0, 1'b0);
    rw0 = 32'h12345678;
    rw1 = 32'h9ABCDEF0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", dr_busy, 0);
    chk("rst_cs", rom_cs, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_buf_din", buf_din, 0);
    rst = 1'b0;

    // Unity zoom, addresses {code, ysub, half}
    run_row("t1", 16'h0123, 10'h2A5, 1'b0, 1'b0, 9'd100, 4'd5, 12'h040, 1'b0, 1);
    chk("t1_ncs", cs_addr.size(), 2);
    chk("t1_addr0", (cs_addr.size() > 0) ? cs_addr[0] : 21'h1FFFFF, 21'h0246A);
    chk("t1_addr1", (cs_addr.size() > 1) ? cs_addr[1] : 21'h1FFFFF, 21'h0246B);
    chk("t1_gap", ((cs_gap.size() > 0) ? cs_gap[0] : 0) >= 1, 1);
    chk("t1_latency", (first_we_cyc - start_cyc) >= 5, 1);
    check_row("t1", 16, 15, 100, 1'b0, 'h40, 0, 10'h2A5);

    // Horizontal and vertical flip
    run_row("t2", 16'h0123, 10'h155, 1'b1, 1'b1, 9'd100, 4'd5, 12'h040, 1'b0, 1);
    chk("t2_addr0", (cs_addr.size() > 0) ? cs_addr[0] : 21'h1FFFFF, 21'h02474);
    chk("t2_addr1", (cs_addr.size() > 1) ? cs_addr[1] : 21'h1FFFFF, 21'h02475);
    chk("t2_first_x", (wx.size() > 0) ? wx[0] : -1, 101);
    chk("t2_first_din", (wd.size() > 0) ? wd[0] : 14'h0, {10'h155, 4'hF});
    chk("t2_busyfall", busy_fall_cyc - last_we_cyc, 1);
    check_row("t2", 16, 15, 100, 1'b1, 'h40, 0, 10'h155);

    // Zoom factors, all source pixels opaque
    rw1 = 32'h9ABCDEF1;
    run_row("t3a", 16'h0200, 10'h3FF, 1'b0, 1'b0, 9'd10, 4'd0, 12'h020, 1'b0, 1);
    check_row("t3a", 32, 32, 10, 1'b0, 'h20, 0, 10'h3FF);
    run_row("t3b", 16'h0200, 10'h0F0, 1'b0, 1'b0, 9'd10, 4'd0, 12'h080, 1'b0, 1);
    check_row("t3b", 8, 8, 10, 1'b0, 'h80, 0, 10'h0F0);
    run_row("t3c", 16'h0200, 10'h001, 1'b0, 1'b0, 9'd400, 4'd0, 12'h000, 1'b0, 1);
    chk("t3c_busy", dr_busy, 0);
    check_row("t3c", 256, 256, 400, 1'b0, 0, 0, 10'h001);
    run_row("t3d", 16'h0200, 10'h002, 1'b1, 1'b0, 9'd0, 4'd0, 12'h000, 1'b0, 1);
    check_row("t3d", 256, 256, 0, 1'b1, 0, 0, 10'h002);
    run_row("t3e", 16'h0200, 10'h003, 1'b0, 1'b0, 9'd33, 4'd0, 12'h400, 1'b0, 1);
    check_row("t3e", 1, 1, 33, 1'b0, 'h400, 0, 10'h003);
    run_row("t3f", 16'h0200, 10'h004, 1'b1, 1'b0, 9'd33, 4'd0, 12'hFFF, 1'b0, 1);
    check_row("t3f", 1, 1, 33, 1'b1, 'hFFF, 0, 10'h004);

    // Fraction and x carried into the next tile of the same sprite
    run_row("t4a", 16'h0040, 10'h0AA, 1'b0, 1'b0, 9'd50, 4'd3, 12'h030, 1'b0, 1);
    check_row("t4a", 22, 22, 50, 1'b0, 'h30, 0, 10'h0AA);
    run_row("t4b", 16'h0041, 10'h0AA, 1'b0, 1'b0, 9'd200, 4'd3, 12'h030, 1'b1, 1);
    check_row("t4b", 21, 21, 72, 1'b0, 'h30, 32, 10'h0AA);

    // Slow ROM, two-cycle start pulse
    rom_delay = 7;
    run_row("t5", 16'h0123, 10'h111, 1'b0, 1'b0, 9'd100, 4'd5, 12'h040, 1'b0, 2);
    repeat (10) @(negedge clk);
    rom_delay = 0;
    chk("t5_ncs", cs_addr.size(), 2);
    chk("t5_run0", (cs_run.size() > 0) ? cs_run[0] : 0, 8);
    chk("t5_run1", (cs_run.size() > 1) ? cs_run[1] : 0, 8);
    chk("t5_gap", ((cs_gap.size() > 0) ? cs_gap[0] : 0) >= 1, 1);
    check_row("t5", 16, 16, 100, 1'b0, 'h40, 0, 10'h111);

    // Start pulse during the draw is ignored
    @(negedge clk);
    clear_mon();
    set_row(16'h0123, 10'h222, 1'b0, 1'b0, 9'd20, 4'd5, 12'h040, 1'b0);
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    n = 0;
    while (wx.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5m_started", (wx.size() > 0), 1);
    hpos = 9'd300;
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    wait_idle("t5m");
    repeat (10) @(negedge clk);
    chk("t5m_ncs", cs_addr.size(), 2);
    chk("t5m_busy", dr_busy, 0);
    check_row("t5m", 16, 16, 20, 1'b0, 'h40, 0, 10'h222);

    // Reset in the middle of a draw
    @(negedge clk);
    clear_mon();
    set_row(16'h0300, 10'h333, 1'b0, 1'b0, 9'd0, 4'd0, 12'h000, 1'b0);
    dr_start = 1'b1;
    @(negedge clk);
    dr_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_busy_pre", dr_busy, 1);
    chk("t6_we_pre", buf_we, 1);
    rst = 1'b1;
    #1;
    chk("t6_busy", dr_busy, 0);
    chk("t6_cs", rom_cs, 0);
    chk("t6_we", buf_we, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // hz_keep after reset resumes from cleared state: x = 0 + 1, fraction 0
    run_row("t6", 16'h0123, 10'h044, 1'b0, 1'b0, 9'd100, 4'd5, 12'h040, 1'b1, 1);
    check_row("t6", 16, 16, 1, 1'b0, 'h40, 0, 10'h044);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
